otter_regfile_scoreboard: RTL and testbench

- Parametrised multi-port architectural register file for the out-of-order OTTER core.
- Adds N read and M write ports, plus a per-register busy/tag scoreboard for renaming.
- Provides same-cycle write-to-read bypass and an asynchronous reset that clears all state.
- Sits between dispatch (read/alloc) and writeback/CDB (write). Supersedes the fixed 4-read/1-write negedge file.

---
 rtl/otter_regfile_scoreboard_pkg.sv | 26 ++
 rtl/otter_regfile_scoreboard_bypass_sel.sv | 30 +++
 rtl/otter_regfile_scoreboard.sv | 125 ++++++++++++
 tb/tb_otter_regfile_scoreboard.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_regfile_scoreboard_pkg.sv
// Shared types and default sizing for the OTTER out-of-order register file.
// Holds the write-request record and the address-width helper used by every file.
package otter_rf_pkg;

    localparam int RF_NUM_REGS = 32;
    localparam int RF_DATA_W   = 32;
    localparam int RF_TAG_W    = 4;
    localparam int RF_AW       = $clog2(RF_NUM_REGS);

    typedef logic [RF_TAG_W-1:0]  rf_tag_t;
    typedef logic [RF_AW-1:0]     rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

    typedef struct packed {
        logic     en;
        rf_addr_t addr;
        rf_data_t data;
        rf_tag_t  tag;
    } rf_wr_req_t;

    // Address width for a register count; a single register still needs one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/otter_regfile_scoreboard_bypass_sel.sv
// Per-read-port bypass mux: picks the highest-index accepted write that targets
// this port's address, so the newest writeback wins on a same-register conflict.
module otter_rf_bypass_sel
    import otter_rf_pkg::*;
#(
    parameter int NUM_WRITE = 2,
    parameter int AW        = RF_AW,
    parameter int DATA_W    = RF_DATA_W
) (
    input  logic [NUM_WRITE-1:0]        wr_eff_i,
    input  logic [NUM_WRITE*AW-1:0]     wr_addr_i,
    input  logic [NUM_WRITE*DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]               rd_addr_i,
    output logic                        hit_o,
    output logic [DATA_W-1:0]           data_o
);

    // NOTE: every output gets a default before the loop so no path infers a latch.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (wr_eff_i[w] && (wr_addr_i[w*AW +: AW] == rd_addr_i)) begin
                hit_o  = 1'b1;
                data_o = wr_data_i[w*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/otter_regfile_scoreboard.sv
// Multi-port architectural register file with a busy/tag scoreboard for renaming.
// Reads are combinational and see this cycle's accepted writes; alloc and flush land at the edge.
module otter_regfile_scoreboard
    import otter_rf_pkg::*;
#(
    parameter int NUM_READ  = 4,
    parameter int NUM_WRITE = 2,
    parameter int DATA_W    = RF_DATA_W,
    parameter int NUM_REGS  = RF_NUM_REGS,
    parameter int TAG_W     = RF_TAG_W,
    parameter int CHECK_TAG = 1,
    localparam int AW       = addr_w(NUM_REGS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_READ*AW-1:0]      rd_addr,
    output logic [NUM_READ*DATA_W-1:0]  rd_data,
    output logic [NUM_READ-1:0]         rd_busy,
    output logic [NUM_READ*TAG_W-1:0]   rd_tag,
    input  logic [NUM_WRITE-1:0]        wr_en,
    input  logic [NUM_WRITE*AW-1:0]     wr_addr,
    input  logic [NUM_WRITE*DATA_W-1:0] wr_data,
    input  logic [NUM_WRITE*TAG_W-1:0]  wr_tag,
    input  logic                        alloc_en,
    input  logic [AW-1:0]               alloc_addr,
    input  logic [TAG_W-1:0]            alloc_tag,
    input  logic                        flush
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [TAG_W-1:0]    tag_q  [NUM_REGS];
    logic [TAG_W-1:0]    tag_d  [NUM_REGS];

    logic [AW-1:0]       wa [NUM_WRITE];
    logic [DATA_W-1:0]   wd [NUM_WRITE];
    logic [TAG_W-1:0]    wt [NUM_WRITE];
    logic [NUM_WRITE-1:0] wr_eff;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    // A write is accepted only for a real register whose producer tag it carries.
    for (genvar w = 0; w < NUM_WRITE; w++) begin : g_wr
        assign wa[w] = wr_addr[w*AW +: AW];
        assign wd[w] = wr_data[w*DATA_W +: DATA_W];
        assign wt[w] = wr_tag[w*TAG_W +: TAG_W];
        assign wr_eff[w] = wr_en[w] && (wa[w] != '0) && in_range(wa[w]) &&
                           ((CHECK_TAG == 0) ||
                            (busy_q[wa[w]] && (tag_q[wa[w]] == wt[w])));
    end

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (wr_eff[w]) begin
                regs_d[wa[w]] = wd[w];
                busy_d[wa[w]] = 1'b0;
                tag_d[wa[w]]  = '0;
            end
        end
        // Flush wins over alloc; alloc wins over a same-register write clear.
        if (flush) begin
            busy_d = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                tag_d[i] = '0;
            end
        end else if (alloc_en && (alloc_addr != '0) && in_range(alloc_addr)) begin
            busy_d[alloc_addr] = 1'b1;
            tag_d[alloc_addr]  = alloc_tag;
        end
    end

    // NOTE: the storage array is reset deliberately, since reset must clear every register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
        logic [AW-1:0]     ra;
        logic              valid;
        logic              hit;
        logic [DATA_W-1:0] byp_data;
        logic              busy_r;

        assign ra    = rd_addr[r*AW +: AW];
        assign valid = !reset && (ra != '0) && in_range(ra);

        otter_rf_bypass_sel #(
            .NUM_WRITE (NUM_WRITE),
            .AW        (AW),
            .DATA_W    (DATA_W)
        ) u_bypass (
            .wr_eff_i  (wr_eff),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .rd_addr_i (ra),
            .hit_o     (hit),
            .data_o    (byp_data)
        );

        // An accepted write this cycle already retires the producer for this reader.
        assign busy_r = valid && busy_q[ra] && !hit;

        assign rd_data[r*DATA_W +: DATA_W] = !valid ? '0 : (hit ? byp_data : regs_q[ra]);
        assign rd_busy[r]                  = busy_r;
        assign rd_tag[r*TAG_W +: TAG_W]    = busy_r ? tag_q[ra] : '0;
    end

endmodule

// File: tb/tb_otter_regfile_scoreboard.sv
// Directed bench for otter_regfile_scoreboard: expected reads are queued as stimulus
// is driven and compared against the read ports once the cycle's inputs settle.
module tb_otter_regfile_scoreboard;
    import otter_rf_pkg::*;

    localparam int NR = 4;
    localparam int NW = 2;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TW = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic [NR*AW-1:0]   rd_addr;
    logic [NR*DW-1:0]   rd_data;
    logic [NR-1:0]      rd_busy;
    logic [NR*TW-1:0]   rd_tag;
    logic [NW-1:0]      wr_en;
    logic [NW*AW-1:0]   wr_addr;
    logic [NW*DW-1:0]   wr_data;
    logic [NW*TW-1:0]   wr_tag;
    logic               alloc_en;
    logic [AW-1:0]      alloc_addr;
    logic [TW-1:0]      alloc_tag;
    logic               flush;

    rf_wr_req_t wr_req [NW];

    typedef struct {
        string       name;
        int          port;
        logic [31:0] data;
        logic        busy;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    for (genvar w = 0; w < NW; w++) begin : g_pack
        assign wr_en[w]              = wr_req[w].en;
        assign wr_addr[w*AW +: AW]   = wr_req[w].addr;
        assign wr_data[w*DW +: DW]   = wr_req[w].data;
        assign wr_tag[w*TW +: TW]    = wr_req[w].tag;
    end

    otter_regfile_scoreboard #(
        .NUM_READ  (NR),
        .NUM_WRITE (NW),
        .DATA_W    (DW),
        .NUM_REGS  (32),
        .TAG_W     (TW),
        .CHECK_TAG (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .rd_tag     (rd_tag),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_tag     (wr_tag),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .alloc_tag  (alloc_tag),
        .flush      (flush)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        for (int w = 0; w < NW; w++) begin
            wr_req[w] = '0;
        end
        alloc_en   = 1'b0;
        alloc_addr = '0;
        alloc_tag  = '0;
        flush      = 1'b0;
    endtask

    task automatic do_wr(input int w, input logic [AW-1:0] a, input logic [TW-1:0] t,
                         input logic [DW-1:0] d);
        wr_req[w] = '{en: 1'b1, addr: a, data: d, tag: t};
    endtask

    task automatic do_alloc(input logic [AW-1:0] a, input logic [TW-1:0] t);
        alloc_en   = 1'b1;
        alloc_addr = a;
        alloc_tag  = t;
    endtask

    task automatic expect_rd(input string name, input int port, input logic [AW-1:0] a,
                             input logic [31:0] d, input logic b, input logic [3:0] t);
        exp_t e;
        rd_addr[port*AW +: AW] = a;
        e.name = name;
        e.port = port;
        e.data = d;
        e.busy = b;
        e.tag  = t;
        sb.push_back(e);
    endtask

    task automatic compare_all();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, ".data"}, rd_data[e.port*DW +: DW], e.data);
            check({e.name, ".busy"}, {31'b0, rd_busy[e.port]}, {31'b0, e.busy});
            check({e.name, ".tag"},  {28'b0, rd_tag[e.port*TW +: TW]}, {28'b0, e.tag});
        end
    endtask

    task automatic begin_cycle();
        @(negedge clock);
        idle();
    endtask

    task automatic end_cycle();
        @(posedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        rd_addr = '0;
        idle();
        #2;
        expect_rd("rst_x0",  0, 5'd0,  32'h0, 1'b0, 4'h0);
        expect_rd("rst_x5",  1, 5'd5,  32'h0, 1'b0, 4'h0);
        expect_rd("rst_x31", 2, 5'd31, 32'h0, 1'b0, 4'h0);
        expect_rd("rst_p3",  3, 5'd0,  32'h0, 1'b0, 4'h0);
        compare_all();
        @(negedge clock);
        reset = 1'b0;

        // A write to a non-busy register is dropped; alloc is not visible this cycle.
        begin_cycle();
        do_wr(0, 5'd5, 4'h0, 32'h99);
        do_alloc(5'd5, 4'h3);
        expect_rd("s1_x5", 0, 5'd5, 32'h0, 1'b0, 4'h0);
        compare_all();
        end_cycle();

        begin_cycle();
        expect_rd("s2_x5_alloc", 0, 5'd5, 32'h0, 1'b1, 4'h3);
        compare_all();
        end_cycle();

        begin_cycle();
        do_wr(0, 5'd5, 4'h3, 32'hDEADBEEF);
        expect_rd("s3_x5_bypass", 1, 5'd5, 32'hDEADBEEF, 1'b0, 4'h0);
        compare_all();
        end_cycle();

        begin_cycle();
        expect_rd("s4_x5_held", 2, 5'd5, 32'hDEADBEEF, 1'b0, 4'h0);
        compare_all();
        end_cycle();

        begin_cycle();
        do_alloc(5'd7, 4'h2);
        end_cycle();

        begin_cycle();
        do_alloc(5'd7, 4'h6);
        expect_rd("s6_x7_tag2", 0, 5'd7, 32'h0, 1'b1, 4'h2);
        compare_all();
        end_cycle();

        begin_cycle();
        do_wr(0, 5'd7, 4'h2, 32'h11);
        expect_rd("s7_x7_stale", 0, 5'd7, 32'h0, 1'b1, 4'h6);
        compare_all();
        end_cycle();

        begin_cycle();
        do_wr(1, 5'd7, 4'h6, 32'h22);
        expect_rd("s8_x7_bypass", 3, 5'd7, 32'h22, 1'b0, 4'h0);
        compare_all();
        end_cycle();

        begin_cycle();
        expect_rd("s9_x7_held", 0, 5'd7, 32'h22, 1'b0, 4'h0);
        do_alloc(5'd9, 4'h5);
        compare_all();
        end_cycle();

        // Both ports hit x9: the higher port index must win.
        begin_cycle();
        do_wr(0, 5'd9, 4'h5, 32'hAA);
        do_wr(1, 5'd9, 4'h5, 32'hBB);
        expect_rd("s11_x9_prio", 1, 5'd9, 32'hBB, 1'b0, 4'h0);
        compare_all();
        end_cycle();

        begin_cycle();
        do_wr(0, 5'd0, 4'h0, 32'hFF);
        do_alloc(5'd0, 4'h2);
        expect_rd("s12_x0_wr", 0, 5'd0, 32'h0, 1'b0, 4'h0);
        expect_rd("s12_x9_held", 1, 5'd9, 32'hBB, 1'b0, 4'h0);
        compare_all();
        end_cycle();

        begin_cycle();
        expect_rd("s13_x0_after", 0, 5'd0, 32'h0, 1'b0, 4'h0);
        do_alloc(5'd4, 4'h1);
        compare_all();
        end_cycle();

        // Write retires tag 1 while a new alloc claims x4 in the same cycle.
        begin_cycle();
        do_wr(0, 5'd4, 4'h1, 32'h55);
        do_alloc(5'd4, 4'h8);
        expect_rd("s15_x4_same", 0, 5'd4, 32'h55, 1'b0, 4'h0);
        compare_all();
        end_cycle();

        begin_cycle();
        expect_rd("s16_x4_realloc", 0, 5'd4, 32'h55, 1'b1, 4'h8);
        do_alloc(5'd3, 4'h1);
        compare_all();
        end_cycle();

        begin_cycle();
        do_alloc(5'd6, 4'h2);
        expect_rd("s18_x3", 0, 5'd3, 32'h0, 1'b1, 4'h1);
        compare_all();
        end_cycle();

        begin_cycle();
        do_alloc(5'd10, 4'h3);
        end_cycle();

        begin_cycle();
        flush = 1'b1;
        do_alloc(5'd12, 4'h4);
        do_wr(0, 5'd6, 4'h2, 32'h66);
        expect_rd("s20_x6_bypass",   0, 5'd6,  32'h66, 1'b0, 4'h0);
        expect_rd("s20_x3_preflush", 1, 5'd3,  32'h0,  1'b1, 4'h1);
        expect_rd("s20_x10_preflush",2, 5'd10, 32'h0,  1'b1, 4'h3);
        expect_rd("s20_x12_pending", 3, 5'd12, 32'h0,  1'b0, 4'h0);
        compare_all();
        end_cycle();

        begin_cycle();
        expect_rd("s21_x3_flushed",  0, 5'd3,  32'h0,  1'b0, 4'h0);
        expect_rd("s21_x6_flushed",  1, 5'd6,  32'h66, 1'b0, 4'h0);
        expect_rd("s21_x10_flushed", 2, 5'd10, 32'h0,  1'b0, 4'h0);
        expect_rd("s21_x12_dropped", 3, 5'd12, 32'h0,  1'b0, 4'h0);
        compare_all();
        end_cycle();

        begin_cycle();
        expect_rd("s22_x5_kept", 0, 5'd5, 32'hDEADBEEF, 1'b0, 4'h0);
        expect_rd("s22_x7_kept", 1, 5'd7, 32'h22,       1'b0, 4'h0);
        expect_rd("s22_x9_kept", 2, 5'd9, 32'hBB,       1'b0, 4'h0);
        expect_rd("s22_x4_kept", 3, 5'd4, 32'h55,       1'b0, 4'h0);
        do_alloc(5'd20, 4'h7);
        compare_all();
        end_cycle();

        // Reset raised between edges must zero the outputs without a clock.
        begin_cycle();
        do_wr(0, 5'd20, 4'h7, 32'h1234);
        expect_rd("s24_x20_bypass", 0, 5'd20, 32'h1234, 1'b0, 4'h0);
        compare_all();
        #2;
        reset = 1'b1;
        expect_rd("mid_rst_x20", 0, 5'd20, 32'h0, 1'b0, 4'h0);
        expect_rd("mid_rst_x5",  1, 5'd5,  32'h0, 1'b0, 4'h0);
        expect_rd("mid_rst_x9",  2, 5'd9,  32'h0, 1'b0, 4'h0);
        expect_rd("mid_rst_x4",  3, 5'd4,  32'h0, 1'b0, 4'h0);
        compare_all();
        end_cycle();

        begin_cycle();
        reset = 1'b0;
        expect_rd("post_rst_x20", 0, 5'd20, 32'h0, 1'b0, 4'h0);
        expect_rd("post_rst_x5",  1, 5'd5,  32'h0, 1'b0, 4'h0);
        expect_rd("post_rst_x7",  2, 5'd7,  32'h0, 1'b0, 4'h0);
        expect_rd("post_rst_x6",  3, 5'd6,  32'h0, 1'b0, 4'h0);
        compare_all();
        end_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
